// File: rtl/obi_wb_bridge_pkg.sv
// Shared types for the OBI-to-Wishbone bridge: FSM state and request/response bundles.
package obi_wb_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = DataWidth / 8;

  typedef enum logic [0:0] {
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } obi_rsp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] adr;
    logic                 we;
    logic [BeWidth-1:0]   sel;
    logic [DataWidth-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/obi_wb_bridge_if.sv
// OBI core port plus pipelined Wishbone master port, as seen by one bridge instance.
// Signal suffixes are relative to the bridge.
interface obi_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    obi_req_i;
  logic                    obi_gnt_o;
  logic [ADDR_WIDTH-1:0]   obi_addr_i;
  logic                    obi_we_i;
  logic [DATA_WIDTH/8-1:0] obi_be_i;
  logic [DATA_WIDTH-1:0]   obi_wdata_i;
  logic                    obi_rvalid_o;
  logic [DATA_WIDTH-1:0]   obi_rdata_o;
  logic                    obi_err_o;

  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_stall_i;

  // Bridge view: it is the Wishbone master.
  modport master (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  // Environment view: core requester and Wishbone slave.
  modport slave (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

endinterface

// File: rtl/obi_wb_bridge_timeout.sv
// Idle-response watchdog: counts enabled cycles, pulses expired_o on the last one.
module obi_wb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i & ~clr_i & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Next count: restart after expiry so a fresh window begins.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expired_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/obi_wb_bridge.sv
// OBI request/grant/rvalid port to pipelined Wishbone master, with bounded outstanding
// transfers, registered responses and a hung-slave abort that errors out pending transfers.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = AddrWidth,
  parameter int unsigned DATA_WIDTH      = DataWidth,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input logic            clk_i,
  input logic            rst_ni,
  obi_wb_bridge_if.master bus
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  state_e          state_q, state_d;
  logic            stb_q, stb_d;
  wb_req_t         wb_req_q, wb_req_d;
  obi_rsp_t        rsp_q, rsp_d;
  logic            rvalid_q, rvalid_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic [CntW-1:0] pend, pend_after;
  obi_req_t        obi_req;
  logic            run, issue, ack_any, ack_valid, gnt, tmo_en, expired;

  assign obi_req = '{
    addr:  AddrWidth'(bus.obi_addr_i),
    we:    bus.obi_we_i,
    be:    BeWidth'(bus.obi_be_i),
    wdata: DataWidth'(bus.obi_wdata_i)
  };

  assign run     = (state_q == RUN);
  assign issue   = stb_q & ~bus.wb_stall_i;
  assign ack_any = bus.wb_ack_i | bus.wb_err_i;
  // An ack with nothing in flight (and nothing leaving this cycle) belongs to no transfer.
  assign ack_valid  = run & ack_any & ((outst_q != '0) | issue);
  assign pend       = outst_q + CntW'(stb_q);
  assign pend_after = pend - CntW'(ack_valid);
  // Withhold grant on the expiry cycle so no request slips past the drain count.
  assign gnt = bus.obi_req_i & run & ~expired & (~stb_q | ~bus.wb_stall_i) &
               (pend_after < CntW'(MAX_OUTSTANDING));

  assign tmo_en = run & (outst_q != '0) & ~ack_any;

  obi_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (tmo_en),
    .clr_i    (~tmo_en),
    .expired_o(expired)
  );

  // Next-state for strobe, request, outstanding count, drain count and response.
  always_comb begin
    state_d  = state_q;
    stb_d    = stb_q;
    wb_req_d = wb_req_q;
    outst_d  = outst_q;
    drain_d  = drain_q;
    rvalid_d = 1'b0;
    rsp_d    = '{rdata: '0, err: 1'b0};
    unique case (state_q)
      RUN: begin
        if (gnt) begin
          stb_d    = 1'b1;
          wb_req_d = '{adr: obi_req.addr, we: obi_req.we, sel: obi_req.be, dat: obi_req.wdata};
        end else if (issue) begin
          stb_d = 1'b0;
        end
        outst_d     = outst_q + CntW'(issue) - CntW'(ack_valid);
        rvalid_d    = ack_valid;
        rsp_d.err   = ack_valid & bus.wb_err_i;
        rsp_d.rdata = DataWidth'(bus.wb_dat_i);
        if (expired) begin
          state_d = DRAIN;
          stb_d   = 1'b0;
          outst_d = '0;
          drain_d = pend;
        end
      end
      DRAIN: begin
        // Slave responses are ignored; every abandoned transfer gets an error.
        if (drain_q != '0) begin
          rvalid_d  = 1'b1;
          rsp_d.err = 1'b1;
          drain_d   = drain_q - CntW'(1);
        end
        if (drain_q <= CntW'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      stb_q    <= 1'b0;
      wb_req_q <= '0;
      outst_q  <= '0;
      drain_q  <= '0;
      rvalid_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      wb_req_q <= wb_req_d;
      outst_q  <= outst_d;
      drain_q  <= drain_d;
      rvalid_q <= rvalid_d;
      rsp_q    <= rsp_d;
    end
  end

  assign bus.obi_gnt_o    = gnt;
  assign bus.obi_rvalid_o = rvalid_q;
  assign bus.obi_rdata_o  = DATA_WIDTH'(rsp_q.rdata);
  assign bus.obi_err_o    = rsp_q.err;

  assign bus.wb_cyc_o = run & (stb_q | (outst_q != '0));
  assign bus.wb_stb_o = stb_q;
  assign bus.wb_we_o  = wb_req_q.we;
  assign bus.wb_sel_o = BeW'(wb_req_q.sel);
  assign bus.wb_adr_o = ADDR_WIDTH'(wb_req_q.adr);
  assign bus.wb_dat_o = DATA_WIDTH'(wb_req_q.dat);

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed bench for obi_wb_bridge with MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8.
module tb_obi_wb_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rv_cnt;

  always #5 clk = ~clk;

  obi_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  obi_wb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MAX_OUTSTANDING(2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata, input logic ack,
                       input logic err, input logic stall, input logic [31:0] rdat);
    bus.obi_req_i   = req;
    bus.obi_addr_i  = addr;
    bus.obi_we_i    = we;
    bus.obi_be_i    = be;
    bus.obi_wdata_i = wdata;
    bus.wb_ack_i    = ack;
    bus.wb_err_i    = err;
    bus.wb_stall_i  = stall;
    bus.wb_dat_i    = rdat;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_gnt", bus.obi_gnt_o, 0);
    check("rst_rvalid", bus.obi_rvalid_o, 0);
    check("rst_err", bus.obi_err_o, 0);
    check("rst_rdata", bus.obi_rdata_o, 0);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_stb", bus.wb_stb_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read: ack two cycles after stb
    cyc_next(); drive(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0);
    check("rd_gnt", bus.obi_gnt_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_stb", bus.wb_stb_o, 1);
    check("rd_adr", bus.wb_adr_o, 32'h100);
    check("rd_we", bus.wb_we_o, 0);
    check("rd_cyc", bus.wb_cyc_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_stb_drop", bus.wb_stb_o, 0);
    check("rd_cyc_hold", bus.wb_cyc_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF);
    check("rd_rvalid_early", bus.obi_rvalid_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_rvalid", bus.obi_rvalid_o, 1);
    check("rd_rdata", bus.obi_rdata_o, 32'hDEADBEEF);
    check("rd_err", bus.obi_err_o, 0);
    check("rd_cyc_end", bus.wb_cyc_o, 0);

    // Back-to-back writes, ack one cycle after each stb
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_next();
      drive(i < 4, 32'h200 + 32'(4 * i), 1, 4'hF, 32'(i + 1), (i >= 2) && (i <= 5), 0, 0, 0);
      if (i < 4) check("wr_gnt", bus.obi_gnt_o, 1);
      if (i >= 1 && i <= 4) begin
        check("wr_stb", bus.wb_stb_o, 1);
        check("wr_dat", bus.wb_dat_o, 32'(i));
        check("wr_we", bus.wb_we_o, 1);
      end
      check("wr_rvalid", bus.obi_rvalid_o, (i >= 3) && (i <= 6));
      check("wr_err", bus.obi_err_o, 0);
      if (bus.obi_rvalid_o) rv_cnt++;
      if (i == 7) check("wr_cyc_end", bus.wb_cyc_o, 0);
    end
    check("wr_rvalid_count", rv_cnt, 4);

    // Stall held 3 cycles on the first request
    cyc_next(); drive(1, 32'h300, 1, 4'h3, 32'hA5A50001, 0, 0, 0, 0);
    check("st_gnt_a", bus.obi_gnt_o, 1);
    for (int j = 0; j < 3; j++) begin
      cyc_next(); drive(1, 32'h304, 1, 4'hC, 32'h5A5A0002, 0, 0, 1, 0);
      check("st_gnt_b_blocked", bus.obi_gnt_o, 0);
      check("st_stb", bus.wb_stb_o, 1);
      check("st_adr", bus.wb_adr_o, 32'h300);
      check("st_dat", bus.wb_dat_o, 32'hA5A50001);
      check("st_sel", bus.wb_sel_o, 4'h3);
    end
    cyc_next(); drive(1, 32'h304, 1, 4'hC, 32'h5A5A0002, 0, 0, 0, 0);
    check("st_gnt_b_release", bus.obi_gnt_o, 1);
    check("st_adr_release", bus.wb_adr_o, 32'h300);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("st_adr_b", bus.wb_adr_o, 32'h304);
    check("st_sel_b", bus.wb_sel_o, 4'hC);
    check("st_rvalid_none", bus.obi_rvalid_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("st_rvalid_a", bus.obi_rvalid_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("st_rvalid_b", bus.obi_rvalid_o, 1);
    check("st_cyc_end", bus.wb_cyc_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("st_rvalid_idle", bus.obi_rvalid_o, 0);

    // Outstanding limit
    cyc_next(); drive(1, 32'h400, 0, 4'hF, 0, 0, 0, 0, 0);
    check("lim_gnt1", bus.obi_gnt_o, 1);
    cyc_next(); drive(1, 32'h404, 0, 4'hF, 0, 0, 0, 0, 0);
    check("lim_gnt2", bus.obi_gnt_o, 1);
    cyc_next(); drive(1, 32'h408, 0, 4'hF, 0, 0, 0, 0, 0);
    check("lim_gnt3_blocked", bus.obi_gnt_o, 0);
    cyc_next(); drive(1, 32'h408, 0, 4'hF, 0, 0, 0, 0, 0);
    check("lim_gnt3_still", bus.obi_gnt_o, 0);
    check("lim_cyc", bus.wb_cyc_o, 1);
    cyc_next(); drive(1, 32'h408, 0, 4'hF, 0, 1, 0, 0, 32'h11);
    check("lim_gnt3_on_ack", bus.obi_gnt_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h22);
    check("lim_stb3", bus.wb_stb_o, 1);
    check("lim_adr3", bus.wb_adr_o, 32'h408);
    check("lim_rvalid1", bus.obi_rvalid_o, 1);
    check("lim_rdata1", bus.obi_rdata_o, 32'h11);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h33);
    check("lim_rvalid2", bus.obi_rvalid_o, 1);
    check("lim_rdata2", bus.obi_rdata_o, 32'h22);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lim_rvalid3", bus.obi_rvalid_o, 1);
    check("lim_rdata3", bus.obi_rdata_o, 32'h33);
    check("lim_cyc_end", bus.wb_cyc_o, 0);

    // Timeout with 2 outstanding, no ack
    cyc_next(); drive(1, 32'h500, 0, 4'hF, 0, 0, 0, 0, 0);
    check("to_gnt1", bus.obi_gnt_o, 1);
    cyc_next(); drive(1, 32'h504, 0, 4'hF, 0, 0, 0, 0, 0);
    check("to_gnt2", bus.obi_gnt_o, 1);
    for (int k = 2; k <= 9; k++) begin
      cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("to_cyc_wait", bus.wb_cyc_o, 1);
      check("to_rvalid_wait", bus.obi_rvalid_o, 0);
    end
    cyc_next(); drive(1, 32'h508, 0, 4'hF, 0, 0, 0, 0, 0);
    check("to_cyc_drop", bus.wb_cyc_o, 0);
    check("to_gnt_drain", bus.obi_gnt_o, 0);
    check("to_rvalid_pre", bus.obi_rvalid_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h1234);
    check("to_rvalid1", bus.obi_rvalid_o, 1);
    check("to_err1", bus.obi_err_o, 1);
    check("to_rdata1", bus.obi_rdata_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h1234);
    check("to_rvalid2", bus.obi_rvalid_o, 1);
    check("to_err2", bus.obi_err_o, 1);
    check("to_rdata2", bus.obi_rdata_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("to_late_ack_ignored", bus.obi_rvalid_o, 0);
    check("to_cyc_end", bus.wb_cyc_o, 0);

    // Error response, then spurious ack
    cyc_next(); drive(1, 32'h600, 0, 4'hF, 0, 0, 0, 0, 0);
    check("er_gnt", bus.obi_gnt_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("er_stb", bus.wb_stb_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("er_rvalid", bus.obi_rvalid_o, 1);
    check("er_err", bus.obi_err_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF);
    check("sp_rvalid_pre", bus.obi_rvalid_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sp_rvalid", bus.obi_rvalid_o, 0);
    check("sp_cyc", bus.wb_cyc_o, 0);
    cyc_next(); drive(1, 32'h604, 0, 4'hF, 0, 0, 0, 0, 0);
    check("sp_gnt_after", bus.obi_gnt_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sp_stb_after", bus.wb_stb_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'hCAFE);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sp_rvalid_after", bus.obi_rvalid_o, 1);
    check("sp_rdata_after", bus.obi_rdata_o, 32'hCAFE);
    check("sp_err_after", bus.obi_err_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sp_cyc_end", bus.wb_cyc_o, 0);

    // Reset mid-transfer
    cyc_next(); drive(1, 32'h700, 0, 4'hF, 0, 0, 0, 0, 0);
    check("mr_gnt", bus.obi_gnt_o, 1);
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mr_cyc_pre", bus.wb_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    check("mr_cyc_async", bus.wb_cyc_o, 0);
    check("mr_stb_async", bus.wb_stb_o, 0);
    cyc_next(); drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h77);
    check("mr_rvalid_in_rst", bus.obi_rvalid_o, 0);
    rst_n = 1'b1;
    cyc_next(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mr_rvalid_after", bus.obi_rvalid_o, 0);
    check("mr_cyc_after", bus.wb_cyc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obi_wb_bridge.md
# obi_wb_bridge

Converts one OBI-style request/grant/rvalid port of the `cve2_core` (instruction or data side) into a pipelined Wishbone master port toward the Controller memory. One instance is placed per core port, replacing the ad-hoc ack/data registering in the processor top. The bridge supports up to `MAX_OUTSTANDING` in-flight transfers, registers the response path, and recovers from a hung slave with a bus-error timeout.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width. Byte enables are `DATA_WIDTH/8` wide.
- `MAX_OUTSTANDING`, 2: maximum granted-but-unacknowledged transfers. Legal range 1..4.
- `TIMEOUT_CYCLES`, 1024: cycles without `wb_ack_i`/`wb_err_i` while transfers are pending before the bridge aborts. Must be ≥ 2.
- `clk_i  in  1`: clock.
- `rst_ni  in  1`: reset. One clock; reset is asynchronous and active-low.
- `obi_req_i  in  1`: request valid.
- `obi_gnt_o  out  1`: grant. Combinational from the request and internal state.
- `obi_addr_i  in  ADDR_WIDTH`: byte address.
- `obi_we_i  in  1`: write enable.
- `obi_be_i  in  DATA_WIDTH/8`: byte enables.
- `obi_wdata_i  in  DATA_WIDTH`: write data.
- `obi_rvalid_o  out  1`: response valid, registered.
- `obi_rdata_o  out  DATA_WIDTH`: read data, registered.
- `obi_err_o  out  1`: response error, registered.
- `wb_cyc_o  out  1`: cycle.
- `wb_stb_o  out  1`: strobe.
- `wb_we_o  out  1`: write enable.
- `wb_sel_o  out  DATA_WIDTH/8`: byte select.
- `wb_adr_o  out  ADDR_WIDTH`: address.
- `wb_dat_o  out  DATA_WIDTH`: write data.
- `wb_dat_i  in  DATA_WIDTH`: read data.
- `wb_ack_i  in  1`: acknowledge.
- `wb_err_i  in  1`: error.
- `wb_stall_i  in  1`: pipelined stall.

## Operation
**States**
- RUN: normal operation.
- DRAIN: abort in progress.

**Request path (RUN only)**
- `pend = outstanding + stb_q`.
- `obi_gnt_o = obi_req_i & (state==RUN) & (!stb_q | !wb_stall_i) & (pend_after_issue < MAX_OUTSTANDING)`.
- `pend_after_issue` is `pend`, minus 1 if `wb_ack_i|wb_err_i` this cycle.
- On grant: `stb_q`←1 and the adr/we/sel/dat registers load from the OBI inputs.
- When `stb_q & !wb_stall_i` and no new grant: `stb_q`←0.
- Write data and the address are held stable while `stb_q & wb_stall_i`.

**Outstanding counter** (width clog2(MAX_OUTSTANDING)+1)
- +1 on issue (`stb_q & !wb_stall_i`).
- −1 on `wb_ack_i|wb_err_i`.
- Both in the same cycle: unchanged.
- An ack with `outstanding==0` and no issue this cycle is ignored (no response, no underflow).

**Bus outputs**
- `wb_cyc_o = stb_q | (outstanding != 0)`. Deasserted in DRAIN.
- `wb_stb_o = stb_q`.

**Response path**
- `obi_rvalid_o` ← `wb_ack_i|wb_err_i`.
- `obi_err_o` ← `wb_err_i`.
- `obi_rdata_o` ← `wb_dat_i`.
- The OBI side has no response ready, so the core always accepts.

**Timeout counter**
- Counts while `outstanding != 0` and no ack/err arrives.
- Clears on any ack/err or when `outstanding == 0`.
- On reaching `TIMEOUT_CYCLES−1`: go to DRAIN, drop `stb_q` and `cyc`, latch `drain_cnt = pend`.

**DRAIN**
- Emits one response per cycle with `obi_rvalid_o=1`, `obi_err_o=1`, `obi_rdata_o=0` until `drain_cnt` reaches 0.
- `wb_ack_i`/`wb_err_i` are ignored.
- Then returns to RUN with `outstanding=0`.

## Timing
**Reset values**
- All outputs 0 except `obi_gnt_o`, which is combinational and 0 while `obi_req_i=0`.
- State RUN; all counters 0.

**Latency**
- Grant at cycle N → `wb_stb_o` at N+1.
- Slave ack at cycle M (M ≥ N+1) → `obi_rvalid_o` at M+1.
- Minimum grant-to-rvalid: 2 cycles.

**Throughput**
- Back-to-back grants are possible when `wb_stall_i=0` and the limit allows: one transfer per cycle.

**Ordering**
- Responses are returned in issue order. The Wishbone slave must acknowledge in order.

**Simultaneous events**
- Ack and new issue in the same cycle keep `outstanding` constant.
- Timeout and an ack in the same cycle: the ack wins, the counter clears, no DRAIN.

**Reset mid-transfer**
- Asynchronous clear of all state.
- No response is emitted for in-flight transfers.
- `wb_cyc_o` drops immediately.

## Structure
- `obi_wb_pkg` holds:
  - the `state_e` enum {RUN, DRAIN};
  - the OBI request struct (addr, we, be, wdata);
  - the OBI response struct (rdata, err);
  - the Wishbone request struct.
- One sub-module, `obi_wb_timeout`: the timeout counter with clear/enable, parameterised by `TIMEOUT_CYCLES`, outputting a one-cycle `expired` pulse.
- Everything else is flat.

## Test plan
- **Single read:** `req` with addr 0x100; slave acks with data 0xDEADBEEF two cycles after `stb`.
  - `gnt` in cycle 0, `stb` in cycle 1, `rvalid=1` with `rdata=0xDEADBEEF` in cycle 4.
- **Back-to-back writes, `MAX_OUTSTANDING=2`, slave acks one cycle after each stb:**
  - 4 writes (be 0xF, data 1..4) complete with no gaps in `stb`.
  - Exactly 4 `rvalid` pulses, `err=0`.
- **Stall:** `wb_stall_i` held for 3 cycles on the first request.
  - `adr`/`dat`/`sel` stay constant; `gnt` stays low for the next request until the stall releases.
  - Exactly one issue occurs.
- **Outstanding limit:** slave withholds ack with 2 transfers issued.
  - `gnt=0` for a third `req`.
  - An ack re-enables `gnt` in the same cycle.
- **Timeout, `TIMEOUT_CYCLES=8`, 2 outstanding, no ack:**
  - After 8 cycles `cyc` drops; 2 consecutive `rvalid` with `err=1`, `rdata=0`.
  - A late `wb_ack_i` is ignored.
- **Error and spurious ack:**
  - `wb_err_i` on a read → `rvalid=1`, `err=1`.
  - An ack asserted with nothing outstanding → no `rvalid`, counter stays 0.
